timer_alarm_sched: RTL and testbench

//  Multiplexes N_SLOTS software alarms onto one hardware timer compare channel.
//  It snapshots the running timer value, scans all armed slots with wrap-safe arithmetic,

---
 rtl/timer_alarm_sched_pkg.sv | 10 +
 rtl/timer_alarm_sched.sv | 131 +++++++++++++
 tb/tb_timer_alarm_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/timer_alarm_sched_pkg.sv
// timer_alarm_sched_pkg: shared FSM states, request opcodes and expiry rule
package timer_alarm_sched_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_e;
  localparam logic OP_ARM = 1'b0;
  localparam logic OP_CANCEL = 1'b1;
  localparam int MAX_TW = 64;
  function automatic logic is_expired(input logic [MAX_TW-1:0] delta, input int width);
    return (delta == '0) || delta[width-1];
  endfunction
endpackage

// File: rtl/timer_alarm_sched.sv
// timer_alarm_sched: multiplexes software alarm slots onto one timer compare channel
module timer_alarm_sched
  import timer_alarm_sched_pkg::*;
#(
  parameter int N_SLOTS = 4,
  parameter int TIME_WIDTH = 32,
  localparam int ID_WIDTH = $clog2(N_SLOTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [TIME_WIDTH-1:0] time_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_op_i,
  input  logic [ID_WIDTH-1:0]   req_id_i,
  input  logic [TIME_WIDTH-1:0] req_deadline_i,
  output logic [N_SLOTS-1:0]    pending_o,
  output logic [N_SLOTS-1:0]    fire_o,
  output logic                  cmp_valid_o,
  output logic [TIME_WIDTH-1:0] cmp_value_o,
  output logic [ID_WIDTH-1:0]   cmp_id_o
);
  state_e state_q, state_d;
  logic [ID_WIDTH-1:0] idx_q, idx_d, best_id_q, best_id_d, cmp_id_q, cmp_id_d;
  logic [N_SLOTS-1:0] valid_q, valid_d, exp_q, exp_d;
  logic [N_SLOTS-1:0][TIME_WIDTH-1:0] deadline_q, deadline_d;
  logic [TIME_WIDTH-1:0] snap_q, snap_d, best_delta_q, best_delta_d, cmp_value_q, cmp_value_d;
  logic found_q, found_d, cmp_valid_q, cmp_valid_d;
  logic [TIME_WIDTH-1:0] delta;
  logic expired, last;
  // one slot per SCAN cycle: wrap-safe delta against the snapshot, expiry test
  always_comb begin
    delta = deadline_q[idx_q] - snap_q;
    expired = is_expired(MAX_TW'(delta), TIME_WIDTH);
    last = idx_q == ID_WIDTH'(N_SLOTS - 1);
  end
  // next-state: request handling in IDLE, scan accumulation, fire/clear in UPDATE
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    valid_d = valid_q;
    deadline_d = deadline_q;
    snap_d = snap_q;
    exp_d = exp_q;
    found_d = found_q;
    best_delta_d = best_delta_q;
    best_id_d = best_id_q;
    cmp_valid_d = cmp_valid_q;
    cmp_value_d = cmp_value_q;
    cmp_id_d = cmp_id_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_op_i == OP_ARM) begin
            deadline_d[req_id_i] = req_deadline_i;
            valid_d[req_id_i] = 1'b1;
          end else begin
            valid_d[req_id_i] = 1'b0;
          end
        end
        if (enable_i) begin
          state_d = SCAN;
          snap_d = time_i;
          idx_d = '0;
          exp_d = '0;
          found_d = 1'b0;
        end
      end
      SCAN: begin
        if (valid_q[idx_q]) begin
          if (expired) begin
            exp_d[idx_q] = 1'b1;
          end else if (!found_q || delta < best_delta_q) begin
            found_d = 1'b1;
            best_delta_d = delta;
            best_id_d = idx_q;
          end
        end
        idx_d = idx_q + ID_WIDTH'(1);
        if (last) begin
          state_d = UPDATE;
          cmp_valid_d = found_d;
          cmp_value_d = found_d ? deadline_q[best_id_d] : '0;
          cmp_id_d = found_d ? best_id_d : '0;
        end
      end
      UPDATE: begin
        valid_d = valid_q & ~exp_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset drops every armed slot and aborts any scan
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q <= '0;
      valid_q <= '0;
      deadline_q <= '0;
      snap_q <= '0;
      exp_q <= '0;
      found_q <= 1'b0;
      best_delta_q <= '0;
      best_id_q <= '0;
      cmp_valid_q <= 1'b0;
      cmp_value_q <= '0;
      cmp_id_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      deadline_q <= deadline_d;
      snap_q <= snap_d;
      exp_q <= exp_d;
      found_q <= found_d;
      best_delta_q <= best_delta_d;
      best_id_q <= best_id_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_value_q <= cmp_value_d;
      cmp_id_q <= cmp_id_d;
    end
  end
  assign req_ready_o = state_q == IDLE;
  assign pending_o = valid_q;
  assign fire_o = (state_q == UPDATE) ? exp_q : '0;
  assign cmp_valid_o = cmp_valid_q & enable_i;
  assign cmp_value_o = cmp_value_q;
  assign cmp_id_o = cmp_id_q;
endmodule

// File: tb/tb_timer_alarm_sched.sv
// tb_timer_alarm_sched: random and directed checks against a slot-level alarm model
module tb_timer_alarm_sched;
  localparam int N = 4;
  logic clk = 1'b0, rst_ni = 1'b0, enable_i = 1'b1;
  logic req_valid_i = 1'b0, req_op_i = 1'b0;
  logic [1:0] req_id_i = '0;
  logic [31:0] time_i = '0, req_deadline_i = '0;
  logic req_ready_o, cmp_valid_o;
  logic [N-1:0] pending_o, fire_o;
  logic [31:0] cmp_value_o;
  logic [1:0] cmp_id_o;
  int n_vec = 0, n_err = 0;
  bit m_v[N];
  logic [31:0] m_dl[N];

  timer_alarm_sched dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .time_i(time_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_id_i(req_id_i), .req_deadline_i(req_deadline_i), .pending_o(pending_o),
    .fire_o(fire_o), .cmp_valid_o(cmp_valid_o), .cmp_value_o(cmp_value_o), .cmp_id_o(cmp_id_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] m_pending();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_v[i];
    return r;
  endfunction

  task automatic model_eval(input logic [31:0] t, output logic [N-1:0] em, output logic bv,
                            output logic [31:0] bval, output logic [1:0] bid);
    int remaining, best;
    em = '0; bv = 1'b0; bval = '0; bid = '0; best = 0;
    for (int i = 0; i < N; i++) begin
      if (m_v[i]) begin
        remaining = $signed(m_dl[i] - t);
        if (remaining <= 0) em[i] = 1'b1;
        else if (!bv || remaining < best) begin
          bv = 1'b1; best = remaining; bval = m_dl[i]; bid = 2'(i);
        end
      end
    end
  endtask

  task automatic m_apply(input bit op, input int id, input logic [31:0] dl);
    if (op == 1'b0) begin m_v[id] = 1'b1; m_dl[id] = dl; end
    else m_v[id] = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!req_ready_o && k < 20) begin @(posedge clk); #1; k++; end
    if (!req_ready_o) chk("idle_timeout", req_ready_o, 1);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; req_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pending", pending_o, 0);
    chk("rst_fire", fire_o, 0);
    chk("rst_cmp_valid", cmp_valid_o, 0);
    chk("rst_ready", req_ready_o, 1);
    rst_ni = 1'b1;
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
  endtask

  task automatic run_loop(input bit rq, input bit op, input int id, input logic [31:0] dl,
                          input logic [31:0] t);
    logic [N-1:0] em;
    logic bv;
    logic [31:0] bval;
    logic [1:0] bid;
    wait_idle();
    time_i = t; req_valid_i = rq; req_op_i = op; req_id_i = 2'(id); req_deadline_i = dl;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    if (rq) m_apply(op, id, dl);
    chk("pending", pending_o, m_pending());
    chk("ready_scan", req_ready_o, 0);
    chk("fire_scan", fire_o, 0);
    repeat (N) @(posedge clk);
    #1;
    model_eval(t, em, bv, bval, bid);
    chk("fire", fire_o, em);
    chk("cmp_valid", cmp_valid_o, bv);
    if (bv) begin
      chk("cmp_value", cmp_value_o, bval);
      chk("cmp_id", cmp_id_o, bid);
    end
    for (int i = 0; i < N; i++) if (em[i]) m_v[i] = 1'b0;
  endtask

  task automatic arm_idle(input bit op, input int id, input logic [31:0] dl);
    wait_idle();
    req_valid_i = 1'b1; req_op_i = op; req_id_i = 2'(id); req_deadline_i = dl;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    m_apply(op, id, dl);
    chk("dis_pending", pending_o, m_pending());
    chk("dis_ready", req_ready_o, 1);
    chk("dis_fire", fire_o, 0);
    chk("dis_cmp_valid", cmp_valid_o, 0);
  endtask

  initial begin
    logic [31:0] t;
    int r, id;
    logic [31:0] dl;
    do_reset();
    run_loop(1, 0, 0, 500, 100);
    run_loop(1, 0, 1, 300, 100);
    run_loop(1, 0, 2, 300, 100);
    chk("t2_value", cmp_value_o, 300);
    chk("t2_id", cmp_id_o, 1);
    chk("t2_pending", pending_o, 4'b0111);
    run_loop(0, 0, 0, 0, 200);
    run_loop(0, 0, 0, 0, 300);
    chk("t3_fire", fire_o, 4'b0110);
    run_loop(0, 0, 0, 0, 300);
    chk("t3_value", cmp_value_o, 500);
    chk("t3_id", cmp_id_o, 0);
    chk("t3_pending", pending_o, 4'b0001);
    enable_i = 1'b0;
    wait_idle();
    chk("dis_forced", cmp_valid_o, 0);
    arm_idle(0, 3, 700);
    enable_i = 1'b1;
    do_reset();
    run_loop(1, 0, 3, 32'h10, 32'hFFFF_FFF0);
    run_loop(1, 0, 0, 32'hFFFF_FFF8, 32'hFFFF_FFF0);
    chk("t4_id", cmp_id_o, 0);
    run_loop(0, 0, 0, 0, 32'h11);
    chk("t4_fire3", fire_o[3], 1);
    do_reset();
    run_loop(1, 0, 1, 900, 1000);
    chk("t5_late", fire_o, 4'b0010);
    run_loop(1, 0, 2, 2000, 1000);
    run_loop(1, 1, 2, 0, 1000);
    chk("t5_cancel", cmp_valid_o, 0);
    run_loop(0, 0, 0, 0, 3000);
    chk("t5_nofire", fire_o, 0);
    do_reset();
    enable_i = 1'b0;
    time_i = 100;
    arm_idle(0, 0, 50);
    arm_idle(0, 1, 60);
    enable_i = 1'b1;
    @(posedge clk); #1;
    repeat (2) begin
      chk("t6_fire_scan", fire_o, 0);
      @(posedge clk); #1;
    end
    rst_ni = 1'b0;
    @(posedge clk); #1;
    chk("t6_pending", pending_o, 0);
    chk("t6_fire", fire_o, 0);
    rst_ni = 1'b1;
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    repeat (N + 2) begin
      @(posedge clk); #1;
      chk("t6_quiet", fire_o, 0);
    end
    t = $urandom;
    for (int k = 0; k < 200; k++) begin
      t = t + $urandom_range(0, 300);
      r = $urandom_range(0, 4);
      id = $urandom_range(0, N - 1);
      case ($urandom_range(0, 4))
        0: dl = t;
        1: dl = t + 32'h8000_0000;
        2: dl = t + 32'h7FFF_FFFF;
        3: dl = t - $urandom_range(1, 500);
        default: dl = t + $urandom_range(1, 1000);
      endcase
      run_loop(r != 0, r == 1, id, dl, t);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
